// File: rtl/mem_wb_pipe_stage.sv
// rtl/mem_wb_pipe_stage.sv - MEM to WB pipeline stage with optional skid buffer, flush and forwarding tap
module mem_wb_pipe_stage #(
  parameter int DATA_W  = 8,
  parameter int RD_W    = 2,
  parameter int SEL_W   = 3,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [DATA_W-1:0] in_result,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [SEL_W-1:0]  in_result_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic [SEL_W-1:0]  out_result_sel,
  output logic              fwd_en,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occupancy
);

  localparam int PW = 1 + DATA_W + RD_W + SEL_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        st_q, st_d;
  logic [PW-1:0] h_q, h_d;
  logic [PW-1:0] s_q, s_d;
  logic [PW-1:0] in_pl;
  logic          in_fire;
  logic          out_fire;

  assign in_pl    = {in_reg_write, in_result, in_rd, in_result_sel};
  assign out_valid = (st_q != EMPTY);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Cleared slots are forced to zero so idle outputs never show stale data.
  always_comb begin
    st_d = st_q;
    h_d  = h_q;
    s_d  = s_q;
    if (flush) begin
      st_d = EMPTY;
      h_d  = '0;
      s_d  = '0;
    end else begin
      case (st_q)
        EMPTY: begin
          if (in_fire) begin
            h_d  = in_pl;
            st_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && (out_fire || SKID_EN == 0)) begin
            h_d = in_pl;
          end else if (in_fire) begin
            s_d  = in_pl;
            st_d = FULL;
          end else if (out_fire) begin
            h_d  = '0;
            st_d = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            h_d  = s_q;
            s_d  = '0;
            st_d = ONE;
          end
        end
        default: begin
          st_d = EMPTY;
          h_d  = '0;
          s_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= EMPTY;
      h_q  <= '0;
    end else begin
      st_q <= st_d;
      h_q  <= h_d;
    end
  end

  generate
    if (SKID_EN != 0) begin : g_skid
      logic rdy_q;
      // Ready is registered from the next state so out_ready never reaches in_ready combinationally.
      always_ff @(posedge clk) begin
        if (rst) begin
          s_q   <= '0;
          rdy_q <= 1'b1;
        end else begin
          s_q   <= s_d;
          rdy_q <= (st_d != FULL);
        end
      end
      assign in_ready = rdy_q;
    end else begin : g_noskid
      assign s_q      = '0;
      assign in_ready = (st_q == EMPTY) | out_ready;
    end
  endgenerate

  assign {out_reg_write, out_result, out_rd, out_result_sel} = h_q;

  assign fwd_en    = out_valid & out_reg_write;
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_result;
  assign occupancy = {st_q == FULL, st_q == ONE};

endmodule

// File: doc/mem_wb_pipe_stage.md
# mem_wb_pipe_stage

Parametrised MEM→WB pipeline stage with valid/ready flow control, an optional 2-entry skid buffer, synchronous flush, and a write-back forwarding tap. It sits between the memory stage and the register-file write port. Unlike a plain stage register, it accepts backpressure from write-back without losing a result and without a combinational ready path. It also carries the result-select field end to end.

## Interface

Parameters:
- DATA_W, 8, result width
- RD_W, 2, destination register index width
- SEL_W, 3, write-back result-select width
- SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single register with pass-through ready

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous discard of all held entries
- in_valid  in  1  MEM presents a transaction
- in_ready  out  1  stage can accept this cycle
- in_reg_write  in  1  transaction writes the register file
- in_result  in  DATA_W  result data
- in_rd  in  RD_W  destination register
- in_result_sel  in  SEL_W  write-back mux select
- out_valid  out  1  head entry valid
- out_ready  in  1  WB consumes the head this cycle
- out_reg_write, out_result, out_rd, out_result_sel  out  1/DATA_W/RD_W/SEL_W  head entry fields
- fwd_en  out  1  out_valid & out_reg_write
- fwd_rd  out  RD_W  equals out_rd
- fwd_data  out  DATA_W  equals out_result
- occupancy  out  2  entries held (0..2)

## Operation

- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Storage: head register (H) and, when SKID_EN=1, skid register (S). Each has a valid flag and payload {reg_write, result, rd, result_sel}.
- States when SKID_EN=1 (EMPTY / ONE / FULL):
  - EMPTY: on in-transfer, load H and go to ONE.
  - ONE, in-transfer and out-transfer together: load H with the new entry; stay in ONE.
  - ONE, in-transfer only: load S; go to FULL.
  - ONE, out-transfer only: clear H; go to EMPTY.
  - FULL, out_ready: H ← S, clear S; go to ONE.
  - FULL: no in-transfer is possible.
- in_ready when SKID_EN=1 is !S.valid. It is a register output with no combinational path from out_ready.
- SKID_EN=0: S is not built and occupancy never exceeds 1.
  - in_ready = !H.valid | out_ready (combinational).
  - H loads on every in-transfer.
- Cleared entries have all payload bits zero. Outputs therefore show zero fields whenever out_valid=0.
- Order is strict FIFO. No entry is duplicated or dropped except by flush or rst.
- flush:
  - Next cycle: H and S invalid with zero payloads, occupancy=0, in_ready=1.
  - Any in-transfer in the flush cycle is discarded.
  - out_valid stays as held during the flush cycle itself, so WB may still consume the head that cycle.
- Priority: rst > flush > normal operation.
- Forwarding tap is purely combinational from H, with no added latency.

## Timing

- Reset: after any rising edge with rst=1:
  - out_valid, out_reg_write, out_result, out_rd, out_result_sel = 0
  - fwd_en, fwd_rd, fwd_data = 0
  - occupancy = 0, in_ready = 1
- Reset mid-operation clears held entries in the same edge. No partial state survives.
- Latency: in-transfer at edge N gives out_valid at N+1 (1 cycle) when the stage was EMPTY.
- Throughput: 1 transaction/cycle while out_ready=1.
- Stall: out_ready=0 holds the H outputs stable.
  - SKID_EN=1: accepts exactly one more entry, then drops in_ready the next cycle.
- FULL→ONE on out_ready: in_ready rises one cycle after the head is consumed.
- Simultaneous flush and out_ready in FULL: flush wins and S is discarded, not promoted.
- Payload is sampled only on in-transfer. in_* values are ignored when in_valid=0 or in_ready=0.

## Test plan

- **Reset:** hold rst for 2 cycles with in_valid=1, in_result=8'hAA → all outputs 0, in_ready=1, occupancy=0 throughout and on the first cycle after release.
- **Streaming:** out_ready=1; send results 8'h01, 8'h02, 8'h03 on rd 1, 2, 3 on consecutive cycles → they appear in order, one cycle later each; fwd_en=1 and fwd_rd tracks rd for reg_write=1.
- **Backpressure (SKID_EN=1):** send 8'h10, 8'h11, 8'h12 with out_ready=0 → 8'h10 held on outputs, 8'h11 accepted, occupancy=2, in_ready=0 so 8'h12 is held by the source. Raise out_ready → 8'h10, 8'h11, 8'h12 delivered in order with no loss.
- **Flush while FULL:** stage holds 8'h20 and 8'h21, in_valid=1 with 8'h22, flush=1 → next cycle out_valid=0, out_result=0, occupancy=0, in_ready=1; 8'h22 is never output.
- **SKID_EN=0:** out_ready=0 with H valid → in_ready=0 the same cycle. out_ready=1 with in_valid=1 → H replaced at the edge and occupancy stays 1.
- **reg_write=0 transaction:** rd=2, result 8'h55 → out_valid=1, out_reg_write=0, fwd_en=0.
